// File: rtl/regfile_pkg.sv
// Shared register-file constants and the writeback requester id type.
package regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int NUM_REGS   = 32;
    localparam int ZERO_REG   = 0;

    // Default writeback requester count: ALU, load unit, multiplier.
    localparam int NUM_WB_REQ = 3;
    localparam int REQ_ID_W   = $clog2(NUM_WB_REQ);

    typedef logic [REQ_ID_W-1:0] req_id_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin one-hot arbiter. The search starts at r_ptr and wraps; the pointer
// moves just past the winner after every grant, since the consumer never stalls.
module rr_arbiter #(
    parameter int N = 3,
    localparam int ID_W = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    i_valid,
    output logic [N-1:0]    o_grant,
    output logic [ID_W-1:0] o_grant_id,
    output logic            o_any
);

    logic [ID_W-1:0] r_ptr;
    logic [N-1:0]    w_grant;
    logic [ID_W-1:0] w_id;
    logic            w_any;

    always_comb begin
        int idx;
        idx     = 0;
        w_grant = '0;
        w_id    = '0;
        w_any   = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = int'(r_ptr) + k;
            if (idx >= N) idx = idx - N;
            if (!w_any && i_valid[idx]) begin
                w_any = 1'b1;
                w_id  = ID_W'(idx);
            end
        end
        if (w_any) w_grant[w_id] = 1'b1;
    end

    // Grants are masked while reset is held so no requester sees a handshake.
    assign o_grant    = rst_n ? w_grant : '0;
    assign o_any      = rst_n & w_any;
    assign o_grant_id = w_id;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (w_any) begin
            r_ptr <= (int'(w_id) == N - 1) ? '0 : w_id + 1'b1;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file write port among writeback units and tracks which
// destination registers still have a result outstanding.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int NUM_REQ       = NUM_WB_REQ,
    parameter int ADDR_W        = REG_ADDR_W,
    parameter int DATA_W        = REG_DATA_W,
    parameter bit ZERO_WRITABLE = 1'b0,
    localparam int ID_W = $clog2(NUM_REQ),
    localparam int NREG = 2 ** ADDR_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      rf_write_enable,
    output logic [ADDR_W-1:0]         rf_in_addr,
    output logic [DATA_W-1:0]         rf_in_data,
    output logic [ID_W-1:0]           rf_grant_id,
    input  logic                      rsv_valid,
    input  logic [ADDR_W-1:0]         rsv_addr,
    output logic [NREG-1:0]           busy
);

    logic [NUM_REQ-1:0] w_grant;
    logic [ID_W-1:0]    w_gid;
    logic               w_any;
    logic [ADDR_W-1:0]  w_addr;
    logic [DATA_W-1:0]  w_data;
    logic               w_wr_zero;
    logic               w_rsv_zero;
    logic               w_wr_en;
    logic [NREG-1:0]    w_busy_nxt;

    logic               r_we;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_data;
    logic [ID_W-1:0]    r_id;
    logic [NREG-1:0]    r_busy;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .clk        (clk),
        .rst_n      (reset),
        .i_valid    (req_valid),
        .o_grant    (w_grant),
        .o_grant_id (w_gid),
        .o_any      (w_any)
    );

    assign req_ready = w_grant;

    always_comb begin
        w_addr = '0;
        w_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_addr = req_addr[i*ADDR_W +: ADDR_W];
                w_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Writes to the hard-wired zero register still handshake but never reach the file.
    assign w_wr_zero  = !ZERO_WRITABLE && (w_addr == ADDR_W'(ZERO_REG));
    assign w_rsv_zero = !ZERO_WRITABLE && (rsv_addr == ADDR_W'(ZERO_REG));
    assign w_wr_en    = w_any && !w_wr_zero;

    // Clear first, then set: a same-edge reservation belongs to a newer producer.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_any) w_busy_nxt[w_addr] = 1'b0;
        if (rsv_valid && !w_rsv_zero) w_busy_nxt[rsv_addr] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_we   <= 1'b0;
            r_addr <= '0;
            r_data <= '0;
            r_id   <= '0;
            r_busy <= '0;
        end else begin
            r_we   <= w_wr_en;
            r_busy <= w_busy_nxt;
            if (w_wr_en) begin
                r_addr <= w_addr;
                r_data <= w_data;
                r_id   <= w_gid;
            end
        end
    end

    assign rf_write_enable = r_we;
    assign rf_in_addr      = r_addr;
    assign rf_in_data      = r_data;
    assign rf_grant_id     = r_id;
    assign busy            = r_busy;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: a reference arbiter/busy model
// predicts grants and queues each expected register write.
module tb_regfile_wb_arbiter;
    import regfile_pkg::*;

    localparam int NR = 3;
    localparam int AW = 5;
    localparam int DW = 32;

    logic           clk;
    logic           reset;
    logic [NR-1:0]  req_valid;
    logic [NR*AW-1:0] req_addr;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]  req_ready;
    logic           rf_write_enable;
    logic [AW-1:0]  rf_in_addr;
    logic [DW-1:0]  rf_in_data;
    logic [1:0]     rf_grant_id;
    logic           rsv_valid;
    logic [AW-1:0]  rsv_addr;
    logic [31:0]    busy;

    regfile_wb_arbiter dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_addr        (req_addr),
        .req_data        (req_data),
        .req_ready       (req_ready),
        .rf_write_enable (rf_write_enable),
        .rf_in_addr      (rf_in_addr),
        .rf_in_data      (rf_in_data),
        .rf_grant_id     (rf_grant_id),
        .rsv_valid       (rsv_valid),
        .rsv_addr        (rsv_addr),
        .busy            (busy)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    logic [63:0] exp_q[$];
    int          m_ptr  = 0;
    logic [31:0] m_busy = '0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    // driver tasks
    task automatic set_req(input int i, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[i]         = v;
        req_addr[i*AW +: AW] = a;
        req_data[i*DW +: DW] = d;
    endtask

    task automatic set_rsv(input logic v, input logic [AW-1:0] a);
        rsv_valid = v;
        rsv_addr  = a;
    endtask

    // One clock: predict and check grant, push expected write, check it after the edge.
    task automatic tick();
        logic [NR-1:0] er;
        logic [AW-1:0] a;
        int  g;
        int  idx;
        bit  any;
        bit  exp_we;
        logic [63:0] e;
        #1;
        er  = '0;
        any = 1'b0;
        g   = 0;
        for (int k = 0; k < NR; k++) begin
            idx = (m_ptr + k) % NR;
            if (!any && req_valid[idx]) begin
                any = 1'b1;
                g   = idx;
            end
        end
        if (any) er[g] = 1'b1;
        check("req_ready", 64'(req_ready), 64'(er));
        exp_we = 1'b0;
        if (any) begin
            a = req_addr[g*AW +: AW];
            if (a != 0) begin
                exp_q.push_back(64'({req_id_t'(g), a, req_data[g*DW +: DW]}));
                exp_we = 1'b1;
            end
            m_busy[a] = 1'b0;
            m_ptr = (g + 1) % NR;
        end
        if (rsv_valid && rsv_addr != 0) m_busy[rsv_addr] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rf_write_enable", 64'(rf_write_enable), 64'(exp_we));
        if (exp_we) begin
            e = exp_q.pop_front();
            check("rf_write", 64'({rf_grant_id, rf_in_addr, rf_in_data}), e);
        end
        check("busy", 64'(busy), 64'(m_busy));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_we"},    64'(rf_write_enable), 64'd0);
        check({tag, "_addr"},  64'(rf_in_addr),      64'd0);
        check({tag, "_data"},  64'(rf_in_data),      64'd0);
        check({tag, "_id"},    64'(rf_grant_id),     64'd0);
        check({tag, "_busy"},  64'(busy),            64'd0);
        check({tag, "_ready"}, 64'(req_ready),       64'd0);
    endtask

    initial begin
        reset     = 1'b0;
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;
        rsv_valid = 1'b0;
        rsv_addr  = '0;

        // Reset state, with every requester asking.
        req_valid = 3'b111;
        #1;
        check_all_zero("reset");
        req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Round-robin with all three requesters valid.
        for (int i = 0; i < NR; i++) set_req(i, 1'b1, AW'(i + 1), 32'hA000_0000 + i);
        for (int c = 0; c < 6; c++) tick();

        // Single requester, four back-to-back writes.
        set_req(0, 1'b0, '0, '0);
        set_req(1, 1'b0, '0, '0);
        set_req(2, 1'b1, 5'd7, 32'hDEAD_BEEF);
        for (int c = 0; c < 4; c++) tick();

        // Zero-register write, reservation of r0 also ignored; then req 2 is next.
        set_req(2, 1'b0, '0, '0);
        set_req(1, 1'b1, 5'd0, 32'h0000_1234);
        set_rsv(1'b1, 5'd0);
        tick();
        set_rsv(1'b0, '0);
        for (int i = 0; i < NR; i++) set_req(i, 1'b1, AW'(10 + i), 32'h5500_0000 + i);
        tick();
        check("after_zero_grant_id", 64'(rf_grant_id), 64'd2);

        // Scoreboard: reserve r5, same-edge write+reserve, then plain write.
        req_valid = '0;
        set_rsv(1'b1, 5'd5);
        tick();
        check("busy5_set", 64'(busy[5]), 64'd1);
        set_req(0, 1'b1, 5'd5, 32'h0000_0555);
        tick();
        check("busy5_set_wins", 64'(busy[5]), 64'd1);
        set_rsv(1'b0, '0);
        tick();
        check("busy5_cleared", 64'(busy[5]), 64'd0);

        // Different addresses set and cleared on the same edge.
        req_valid = '0;
        set_rsv(1'b1, 5'd4);
        tick();
        set_rsv(1'b1, 5'd9);
        set_req(1, 1'b1, 5'd4, 32'h0000_0444);
        tick();
        check("busy9_set", 64'(busy[9]), 64'd1);
        check("busy4_clr", 64'(busy[4]), 64'd0);

        // Build busy=0xF0 with a write in flight, then assert reset mid-stream.
        req_valid = '0;
        set_rsv(1'b0, '0);
        set_req(0, 1'b1, 5'd9, 32'h0000_0999);
        tick();
        req_valid = '0;
        for (int r = 4; r < 7; r++) begin
            set_rsv(1'b1, AW'(r));
            tick();
        end
        set_rsv(1'b1, 5'd7);
        set_req(0, 1'b1, 5'd1, 32'hCAFE_0001);
        tick();
        check("busy_pre_reset", 64'(busy), 64'h0000_00F0);
        check("we_pre_reset", 64'(rf_write_enable), 64'd1);
        set_rsv(1'b0, '0);
        for (int i = 0; i < NR; i++) set_req(i, 1'b1, AW'(20 + i), 32'h7700_0000 + i);
        #2;
        reset = 1'b0;
        #1;
        check_all_zero("mid_reset");
        m_ptr  = 0;
        m_busy = '0;
        exp_q.delete();
        @(negedge clk);
        reset = 1'b1;
        tick();
        check("post_reset_id", 64'(rf_grant_id), 64'd0);

        // Random traffic.
        for (int c = 0; c < 60; c++) begin
            for (int i = 0; i < NR; i++)
                set_req(i, 1'(($urandom_range(0, 3)) != 0), AW'($urandom_range(0, 31)), $urandom);
            set_rsv(1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)));
            tick();
        end

        // final report
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
